// File: rtl/d_sramlike_bridge_pkg.sv
// Shared defines for the CPU data/instruction bridges: FSM encoding and
// sram-like transfer size codes.
package d_sramlike_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } bridge_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/d_sramlike_bridge_wen_to_size.sv
// Byte-strobe to sram-like transfer size map. A read (no strobes) and any
// irregular strobe pattern both request a full word.
module wen_to_size
  import d_sramlike_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size
);

  always_comb begin
    size = SIZE_W;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
      4'b0011, 4'b1100:                   size = SIZE_H;
      default:                            size = SIZE_W;
    endcase
  end

endmodule

// File: rtl/d_sramlike_bridge.sv
// CPU data port to sram-like bus bridge: one outstanding transfer, load data
// held until the pipeline advances past the access.
//
// state   | meaning
// IDLE    | no transaction, or request being offered to the slave
// WAIT    | address accepted, waiting for data_ok
// HOLD    | transfer done, result held until the pipeline stops stalling
module d_sramlike_bridge
  import d_sramlike_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_en,
  input  logic [3:0]  cpu_data_wen,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  input  logic        cpu_longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  bridge_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      cpu_data_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      // Writes latch too, so the held value always reflects the last transfer.
      if (state == ST_WAIT && data_data_ok)
        cpu_data_rdata <= data_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    data_req  = cpu_data_en && (state == ST_IDLE);
    d_stall   = cpu_data_en && (state != ST_HOLD);
    case (state)
      ST_IDLE: if (data_req && data_addr_ok) state_nxt = ST_WAIT;
      // Completes even if cpu_data_en has dropped, so no transfer is orphaned.
      ST_WAIT: if (data_data_ok)             state_nxt = ST_HOLD;
      ST_HOLD: if (!cpu_longest_stall)       state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  assign data_wr    = |cpu_data_wen;
  assign data_addr  = cpu_data_addr;
  assign data_wdata = cpu_data_wdata;

  wen_to_size u_wen_to_size (
    .wen  (cpu_data_wen),
    .size (data_size)
  );

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// Directed bench for d_sramlike_bridge: stimulus pushes expected requests and
// load results into queues, a negedge monitor pops and compares them.
module tb_d_sramlike_bridge;

  logic        clk;
  logic        resetn;
  logic        cpu_data_en;
  logic [3:0]  cpu_data_wen;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_longest_stall;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  d_sramlike_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .cpu_data_en       (cpu_data_en),
    .cpu_data_wen      (cpu_data_wen),
    .cpu_data_addr     (cpu_data_addr),
    .cpu_data_wdata    (cpu_data_wdata),
    .cpu_data_rdata    (cpu_data_rdata),
    .cpu_longest_stall (cpu_longest_stall),
    .d_stall           (d_stall),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [31:0] d);
    req_t r;
    r.addr = a; r.wr = w; r.size = s; r.wdata = d;
    req_q.push_back(r);
  endtask

  // Monitor: accepted requests and the first cycle of each held result.
  always @(negedge clk) begin
    if (resetn && data_req && data_addr_ok) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected", 32'd1, 32'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        chk("req_addr", data_addr, r.addr);
        chk("req_wr", {31'd0, data_wr}, {31'd0, r.wr});
        chk("req_size", {30'd0, data_size}, {30'd0, r.size});
        chk("req_wdata", data_wdata, r.wdata);
      end
    end
    if (resetn && prev_busy && cpu_data_en && !d_stall) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_rdata", cpu_data_rdata, rsp_q.pop_front());
    end
    prev_busy <= cpu_data_en && d_stall;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] wen_tab  [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
                                4'b1111, 4'b0000, 4'b0101, 4'b0110, 4'b1110};
  logic [1:0] size_tab [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                                2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

  initial begin
    resetn = 1'b0; cpu_data_en = 1'b1; cpu_data_wen = 4'b0000;
    cpu_data_addr = 32'h0; cpu_data_wdata = 32'h0; cpu_longest_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    // Reset: IDLE behaviour on combinational outputs, cleared load data
    tick(); tick(); look();
    chk("rst_data_req", {31'd0, data_req}, 32'd1);
    chk("rst_d_stall", {31'd0, d_stall}, 32'd1);
    chk("rst_rdata", cpu_data_rdata, 32'h0);
    tick(); cpu_data_en = 1'b0; resetn = 1'b1;

    // Size / write map across strobe patterns
    for (int i = 0; i < 11; i++) begin
      cpu_data_wen = wen_tab[i];
      #1;
      chk("map_size", {30'd0, data_size}, {30'd0, size_tab[i]});
      chk("map_wr", {31'd0, data_wr}, {31'd0, (wen_tab[i] != 4'b0000)});
    end
    cpu_data_wen = 4'b0000;
    tick();

    // Word read, addr_ok in cycle 0, data_ok in cycle 1
    tick(); cpu_data_en = 1'b1; cpu_data_addr = 32'h1FC0_0010; data_addr_ok = 1'b1;
    push_req(32'h1FC0_0010, 1'b0, 2'd2, 32'h0);
    look(); chk("rd_c0_req", {31'd0, data_req}, 32'd1);
    chk("rd_c0_stall", {31'd0, d_stall}, 32'd1);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    rsp_q.push_back(32'hDEAD_BEEF);
    look(); chk("rd_c1_req", {31'd0, data_req}, 32'd0);
    chk("rd_c1_stall", {31'd0, d_stall}, 32'd1);
    tick(); data_data_ok = 1'b0; data_rdata = 32'h0;
    look(); chk("rd_c2_stall", {31'd0, d_stall}, 32'd0);
    chk("rd_c2_req", {31'd0, data_req}, 32'd0);
    tick(); cpu_data_en = 1'b0;
    look(); chk("rd_c3_rdata", cpu_data_rdata, 32'hDEAD_BEEF);

    // Byte store, addr_ok three cycles late
    tick(); cpu_data_en = 1'b1; cpu_data_wen = 4'b0100; cpu_data_addr = 32'h0000_0100;
    cpu_data_wdata = 32'h0000_AB00;
    push_req(32'h0000_0100, 1'b1, 2'd0, 32'h0000_AB00);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) data_addr_ok = 1'b1;
      look(); chk("st_req_held", {31'd0, data_req}, 32'd1);
      if (c < 3) tick();
    end
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    rsp_q.push_back(32'h1234_5678);
    look(); chk("st_wait_stall", {31'd0, d_stall}, 32'd1);
    tick(); data_data_ok = 1'b0;
    look(); chk("st_hold_stall", {31'd0, d_stall}, 32'd0);
    tick(); cpu_data_en = 1'b0; cpu_data_wen = 4'b0000; cpu_data_wdata = 32'h0;

    // HOLD with pipeline stall; stray data_ok in HOLD must be ignored
    tick(); cpu_data_en = 1'b1; cpu_data_addr = 32'h0000_0200; data_addr_ok = 1'b1;
    push_req(32'h0000_0200, 1'b0, 2'd2, 32'h0);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    rsp_q.push_back(32'hCAFE_F00D);
    tick(); data_data_ok = 1'b0; cpu_longest_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA; end
      else data_data_ok = 1'b0;
      look(); chk("hold_stall", {31'd0, d_stall}, 32'd0);
      chk("hold_rdata", cpu_data_rdata, 32'hCAFE_F00D);
      tick();
    end
    data_data_ok = 1'b0; cpu_longest_stall = 1'b0;
    look(); chk("hold_last_stall", {31'd0, d_stall}, 32'd0);
    tick();
    look(); chk("hold_exit_req", {31'd0, data_req}, 32'd1);
    tick(); cpu_data_en = 1'b0;

    // Reset while in WAIT, then a late data_ok
    tick(); cpu_data_en = 1'b1; cpu_data_addr = 32'h0000_0300; data_addr_ok = 1'b1;
    push_req(32'h0000_0300, 1'b0, 2'd2, 32'h0);
    tick(); data_addr_ok = 1'b0; resetn = 1'b0;
    tick(); resetn = 1'b1; cpu_data_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
    look(); chk("rstw_rdata", cpu_data_rdata, 32'h0);
    tick(); data_data_ok = 1'b0; cpu_data_en = 1'b1;
    look(); chk("rstw_late_ok", cpu_data_rdata, 32'h0);
    chk("rstw_idle_req", {31'd0, data_req}, 32'd1);
    tick(); cpu_data_en = 1'b0;

    // Halfword store
    tick(); cpu_data_en = 1'b1; cpu_data_wen = 4'b1100; cpu_data_addr = 32'h0000_0402;
    cpu_data_wdata = 32'h5566_0000; data_addr_ok = 1'b1;
    push_req(32'h0000_0402, 1'b1, 2'd1, 32'h5566_0000);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_BEEF;
    rsp_q.push_back(32'h0000_BEEF);
    tick(); data_data_ok = 1'b0;
    tick(); cpu_data_en = 1'b0; cpu_data_wen = 4'b0000; cpu_data_wdata = 32'h0;

    // Back-to-back reads with en held high
    tick(); cpu_data_en = 1'b1; cpu_data_addr = 32'h0000_0500; data_addr_ok = 1'b1;
    push_req(32'h0000_0500, 1'b0, 2'd2, 32'h0);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    rsp_q.push_back(32'h1111_1111);
    tick(); data_data_ok = 1'b0; cpu_data_addr = 32'h0000_0504;
    look(); chk("b2b_hold_req", {31'd0, data_req}, 32'd0);
    tick(); data_addr_ok = 1'b1;
    push_req(32'h0000_0504, 1'b0, 2'd2, 32'h0);
    look(); chk("b2b_second_req", {31'd0, data_req}, 32'd1);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
    rsp_q.push_back(32'h2222_2222);
    tick(); data_data_ok = 1'b0;
    tick(); cpu_data_en = 1'b0;

    // en drops while in WAIT: transfer still completes and returns to IDLE
    tick(); cpu_data_en = 1'b1; cpu_data_addr = 32'h0000_0600; data_addr_ok = 1'b1;
    push_req(32'h0000_0600, 1'b0, 2'd2, 32'h0);
    tick(); data_addr_ok = 1'b0; cpu_data_en = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'h0BAD_F00D;
    tick(); data_data_ok = 1'b0;
    look(); chk("orphan_rdata", cpu_data_rdata, 32'h0BAD_F00D);
    chk("orphan_req", {31'd0, data_req}, 32'd0);
    tick(); cpu_data_en = 1'b1;
    look(); chk("orphan_idle_req", {31'd0, data_req}, 32'd1);
    tick(); cpu_data_en = 1'b0;

    tick(); tick();
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
